// File: rtl/nyq_decim_fir_pkg.sv
// Shared types and helpers for the decimating Nyquist FIR: FSM state, derived
// widths and the output round/saturate step.
package nyq_pkg;

  typedef enum logic {IDLE, MAC} state_t;

  function automatic int prod_width(input int in_w, input int coef_w);
    return in_w + coef_w;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Round half up by FRAC bits, then optionally clamp to an OW-bit signed range.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int frac, input int ow,
                                                   input logic sat);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (sat && (r > hi)) r = hi;
    else if (sat && (r < lo)) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/nyq_decim_fir_mac.sv
// Registered signed multiply-accumulate; sum is the value the next enabled edge loads.
module nyq_mac
  import nyq_pkg::*;
#(
  parameter int A_WIDTH   = 24,
  parameter int B_WIDTH   = 16,
  parameter int ACC_WIDTH = 48
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        en,
  input  logic signed [A_WIDTH-1:0]   a,
  input  logic signed [B_WIDTH-1:0]   b,
  output logic signed [ACC_WIDTH-1:0] sum
);

  localparam int PW = prod_width(A_WIDTH, B_WIDTH);

  logic signed [PW-1:0]        a_ext;
  logic signed [PW-1:0]        b_ext;
  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] acc;

  assign a_ext = {{B_WIDTH{a[A_WIDTH-1]}}, a};
  assign b_ext = {{A_WIDTH{b[B_WIDTH-1]}}, b};
  assign prod  = a_ext * b_ext;
  assign sum   = acc + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};

  always_ff @(posedge clk) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= sum;
  end

endmodule

// File: rtl/nyq_decim_fir.sv
// Decimating Nyquist FIR with a single time-multiplexed MAC.
// Define NYQ_DECIM_FIR_SAT_EN to saturate the output instead of wrapping it.
module nyq_decim_fir
  import nyq_pkg::*;
#(
  parameter int ADDR_WIDTH  = 5,
  parameter int MEM_WIDTH   = 32,
  parameter int IN_WIDTH    = 24,
  parameter int OUT_WIDTH   = 24,
  parameter int COEFF_WIDTH = 16,
  parameter int NUM_TAPS    = 32,
  parameter int DECIM       = 4,
  parameter int ACC_WIDTH   = 48,
  parameter int FRAC_BITS   = 15
) (
  input  logic                        Clk_CI,
  input  logic                        Rst_RBI,
  input  logic                        WrEn_SI,
  input  logic [ADDR_WIDTH-1:0]       Addr_DI,
  input  logic [MEM_WIDTH-1:0]        PAR_In_DI,
  input  logic                        NYQ_InValid_SI,
  output logic                        NYQ_InReady_SO,
  input  logic signed [IN_WIDTH-1:0]  NYQ_In_DI,
  output logic                        NYQ_OutValid_SO,
  output logic signed [OUT_WIDTH-1:0] NYQ_Out_DO
);

  localparam int IDX_WIDTH = idx_width(NUM_TAPS);
  localparam int PH_WIDTH  = idx_width(DECIM);
`ifdef NYQ_DECIM_FIR_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  state_t                        state;
  logic [IDX_WIDTH-1:0]          idx;
  logic [PH_WIDTH-1:0]           phase;
  logic signed [COEFF_WIDTH-1:0] coef [NUM_TAPS];
  logic signed [IN_WIDTH-1:0]    dl   [NUM_TAPS];
  logic                          accept;
  logic                          group_done;
  logic                          last_tap;
  logic signed [ACC_WIDTH-1:0]   sum;
  logic signed [63:0]            sum_ext;
  logic signed [OUT_WIDTH-1:0]   y;
  logic                          unused_par;

  assign NYQ_InReady_SO = (state == IDLE) & Rst_RBI;
  assign accept         = NYQ_InValid_SI & NYQ_InReady_SO;
  assign group_done     = accept && (phase == PH_WIDTH'(DECIM - 1));
  assign last_tap       = (idx == IDX_WIDTH'(NUM_TAPS - 1));
  assign unused_par     = ^PAR_In_DI;

  // The final tap's product is folded in combinationally so the output lands
  // on the same edge as the last MAC step.
  nyq_mac #(
    .A_WIDTH   (IN_WIDTH),
    .B_WIDTH   (COEFF_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk   (Clk_CI),
    .rst_n (Rst_RBI),
    .clr   (group_done),
    .en    (state == MAC),
    .a     (dl[idx]),
    .b     (coef[idx]),
    .sum   (sum)
  );

  assign sum_ext = {{(64-ACC_WIDTH){sum[ACC_WIDTH-1]}}, sum};
  assign y       = OUT_WIDTH'(round_sat(sum_ext, FRAC_BITS, OUT_WIDTH, SAT_EN));

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      for (int k = 0; k < NUM_TAPS; k++) coef[k] <= '0;
    end else if (WrEn_SI && ({1'b0, Addr_DI} < (ADDR_WIDTH+1)'(NUM_TAPS))) begin
      coef[Addr_DI[IDX_WIDTH-1:0]] <= PAR_In_DI[COEFF_WIDTH-1:0];
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      for (int k = 0; k < NUM_TAPS; k++) dl[k] <= '0;
    end else if (accept) begin
      for (int k = NUM_TAPS - 1; k > 0; k--) dl[k] <= dl[k-1];
      dl[0] <= NYQ_In_DI;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      state           <= IDLE;
      phase           <= '0;
      idx             <= '0;
      NYQ_Out_DO      <= '0;
      NYQ_OutValid_SO <= 1'b0;
    end else begin
      NYQ_OutValid_SO <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            phase <= group_done ? '0 : phase + 1'b1;
            if (group_done) begin
              state <= MAC;
              idx   <= '0;
            end
          end
        end
        MAC: begin
          idx <= idx + 1'b1;
          if (last_tap) begin
            idx             <= '0;
            NYQ_Out_DO      <= y;
            NYQ_OutValid_SO <= 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nyq_decim_fir.sv
// Directed bench for nyq_decim_fir at default parameters.
module tb_nyq_decim_fir;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               wr_en = 1'b0;
  logic [4:0]         addr = '0;
  logic [31:0]        par = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [23:0] in_data = '0;
  logic               out_valid;
  logic signed [23:0] out_data;

  int total = 0;
  int bad   = 0;
  logic signed [23:0] outq [$];

  always #5 clk = ~clk;

  nyq_decim_fir dut (
    .Clk_CI          (clk),
    .Rst_RBI         (rst_n),
    .WrEn_SI         (wr_en),
    .Addr_DI         (addr),
    .PAR_In_DI       (par),
    .NYQ_InValid_SI  (in_valid),
    .NYQ_InReady_SO  (in_ready),
    .NYQ_In_DI       (in_data),
    .NYQ_OutValid_SO (out_valid),
    .NYQ_Out_DO      (out_data)
  );

  always @(negedge clk) if (out_valid === 1'b1) outq.push_back(out_data);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    wr_en = 1'b0;
    repeat (2) tick;
    rst_n = 1'b1;
    #1;
    outq.delete();
  endtask

  task automatic write_coef(input int k, input logic [15:0] v);
    wr_en = 1'b1;
    addr = 5'(k);
    par = {16'h0000, v};
    tick;
    wr_en = 1'b0;
  endtask

  task automatic load_all(input logic [15:0] v);
    for (int k = 0; k < 32; k++) write_coef(k, v);
  endtask

  task automatic send(input logic signed [23:0] x);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = x;
    while (in_ready !== 1'b1 && n < 200) begin
      tick;
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL send_timeout: ready stayed %b, want 1", in_ready);
    end
    tick;
    in_valid = 1'b0;
  endtask

  task automatic send_group(input logic signed [23:0] a, input logic signed [23:0] b,
                            input logic signed [23:0] c, input logic signed [23:0] d);
    send(a);
    send(b);
    send(c);
    send(d);
  endtask

  task automatic get_out(output logic signed [23:0] y);
    int n;
    n = 0;
    while (outq.size() == 0 && n < 200) begin
      tick;
      n++;
    end
    if (outq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL out_timeout: got no pulse, want one");
      y = 'x;
    end else begin
      y = outq.pop_front();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) tick;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_outvalid: got %b want 0", out_valid); end
    total++;
    if (out_data !== 24'sd0) begin bad++; $display("FAIL reset_out: got %0d want 0", out_data); end
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_constant;
    logic signed [23:0] y;
    logic signed [23:0] exp;
    do_reset;
    load_all(16'h4000);
    for (int g = 0; g < 10; g++) begin
      send_group(24'sd1000, 24'sd1000, 24'sd1000, 24'sd1000);
      get_out(y);
      exp = 24'((g < 8 ? g + 1 : 8) * 2000);
      total++;
      if (y !== exp) begin bad++; $display("FAIL const_%0d: got %0d want %0d", g, y, exp); end
    end
  endtask

  task automatic test_impulse;
    logic signed [23:0] y;
    logic signed [23:0] exp;
    do_reset;
    for (int k = 0; k < 32; k++) write_coef(k, 16'((k + 1) * 512));
    for (int g = 0; g < 9; g++) begin
      if (g == 0) send_group(24'sd0, 24'sd0, 24'sd0, 24'sd64);
      else        send_group(24'sd0, 24'sd0, 24'sd0, 24'sd0);
      get_out(y);
      exp = (g < 8) ? 24'(1 + 4 * g) : 24'sd0;
      total++;
      if (y !== exp) begin bad++; $display("FAIL impulse_%0d: got %0d want %0d", g, y, exp); end
    end
  endtask

  task automatic test_rounding;
    logic signed [23:0] y;
    do_reset;
    write_coef(0, 16'h4000);
    send_group(24'sd0, 24'sd0, 24'sd0, 24'sd3);
    get_out(y);
    total++;
    if (y !== 24'sd2) begin bad++; $display("FAIL round_pos: got %0d want 2", y); end
    send_group(24'sd0, 24'sd0, 24'sd0, -24'sd3);
    get_out(y);
    total++;
    if (y !== -24'sd1) begin bad++; $display("FAIL round_neg: got %0d want -1", y); end
  endtask

  task automatic test_saturation;
    logic signed [23:0] y;
    logic signed [63:0] a64;
    logic signed [63:0] r;
    logic signed [23:0] exp;
    do_reset;
    load_all(16'h7FFF);
    for (int g = 0; g < 8; g++) send_group(24'sh7FFFFF, 24'sh7FFFFF, 24'sh7FFFFF, 24'sh7FFFFF);
    for (int g = 0; g < 8; g++) get_out(y);
    a64 = 64'sd32 * 64'sd8388607 * 64'sd32767;
    r = (a64 + 64'sd16384) >>> 15;
`ifdef NYQ_DECIM_FIR_SAT_EN
    exp = 24'sh7FFFFF;
`else
    exp = r[23:0];
`endif
    total++;
    if (y !== exp) begin bad++; $display("FAIL sat_pos: got %0h want %0h", y, exp); end
    for (int g = 0; g < 8; g++) send_group(24'sh800000, 24'sh800000, 24'sh800000, 24'sh800000);
    for (int g = 0; g < 8; g++) get_out(y);
    a64 = 64'sd32 * -64'sd8388608 * 64'sd32767;
    r = (a64 + 64'sd16384) >>> 15;
`ifdef NYQ_DECIM_FIR_SAT_EN
    exp = 24'sh800000;
`else
    exp = r[23:0];
`endif
    total++;
    if (y !== exp) begin bad++; $display("FAIL sat_neg: got %0h want %0h", y, exp); end
  endtask

  task automatic test_handshake;
    logic rdy [73];
    logic ov  [73];
    int acc_a, acc_b, low_run, pulses;
    do_reset;
    in_valid = 1'b1;
    in_data = 24'sd1;
    for (int c = 0; c < 73; c++) begin
      rdy[c] = in_ready;
      ov[c] = out_valid;
      tick;
    end
    in_valid = 1'b0;
    acc_a = 0;
    acc_b = 0;
    pulses = 0;
    for (int c = 0; c < 36; c++) if (rdy[c] === 1'b1) acc_a++;
    for (int c = 36; c < 72; c++) if (rdy[c] === 1'b1) acc_b++;
    for (int c = 0; c < 73; c++) if (ov[c] === 1'b1) pulses++;
    low_run = 0;
    for (int c = 4; c < 73 && rdy[c] === 1'b0; c++) low_run++;
    total++;
    if (acc_a != 4) begin bad++; $display("FAIL hs_accepts_first: got %0d want 4", acc_a); end
    total++;
    if (acc_b != 4) begin bad++; $display("FAIL hs_accepts_second: got %0d want 4", acc_b); end
    total++;
    if (low_run != 32) begin bad++; $display("FAIL hs_ready_low: got %0d want 32", low_run); end
    total++;
    if (ov[36] !== 1'b1) begin bad++; $display("FAIL hs_pulse_e0_32: got %b want 1", ov[36]); end
    total++;
    if (rdy[36] !== 1'b1) begin bad++; $display("FAIL hs_ready_in_pulse: got %b want 1", rdy[36]); end
    total++;
    if (pulses != 2) begin bad++; $display("FAIL hs_pulse_count: got %0d want 2", pulses); end
  endtask

  task automatic test_reset_mid_mac;
    logic signed [23:0] y;
    int rdy_high;
    do_reset;
    load_all(16'h4000);
    send_group(24'sd1000, 24'sd1000, 24'sd1000, 24'sd1000);
    get_out(y);
    total++;
    if (y !== 24'sd2000) begin bad++; $display("FAIL mid_pre: got %0d want 2000", y); end
    send(24'sd1000);
    send(24'sd1000);
    send(24'sd1000);
    in_valid = 1'b1;
    in_data = 24'sd1000;
    tick;
    in_valid = 1'b0;
    repeat (10) tick;
    rst_n = 1'b0;
    rdy_high = 0;
    for (int c = 0; c < 5; c++) begin
      tick;
      if (in_ready !== 1'b0) rdy_high++;
    end
    total++;
    if (rdy_high != 0) begin bad++; $display("FAIL mid_ready_in_reset: got %0d high cycles want 0", rdy_high); end
    total++;
    if (out_data !== 24'sd0) begin bad++; $display("FAIL mid_out_cleared: got %0d want 0", out_data); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_outvalid: got %b want 0", out_valid); end
    rst_n = 1'b1;
    repeat (40) tick;
    total++;
    if (outq.size() != 0) begin bad++; $display("FAIL mid_no_pulse: got %0d pulses want 0", outq.size()); end
    outq.delete();
    send_group(24'sd1000, 24'sd1000, 24'sd1000, 24'sd1000);
    get_out(y);
    total++;
    if (y !== 24'sd0) begin bad++; $display("FAIL mid_coef_cleared: got %0d want 0", y); end
  endtask

  initial begin
    test_reset;
    test_constant;
    test_impulse;
    test_rounding;
    test_saturation;
    test_handshake;
    test_reset_mid_mac;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
